// File: rtl/jelly2_data_player_pkg.sv
// jelly2_data_player_pkg
//   Shared definitions for the data player: Wishbone register word
//   addresses and the bit positions inside CTL_CONTROL / CTL_STATUS.
//   Optional timed playback is selected with `define DATA_PLAYER_TIMED_EN.

package jelly2_data_player_pkg;

    // Register map (word addresses)
    localparam int unsigned ADR_CORE_ID      = 'h00;
    localparam int unsigned ADR_CORE_VERSION = 'h01;
    localparam int unsigned ADR_CTL_CONTROL  = 'h04;
    localparam int unsigned ADR_CTL_STATUS   = 'h05;
    localparam int unsigned ADR_CTL_COUNT    = 'h07;
    localparam int unsigned ADR_CUR_TIMER0   = 'h0c;
    localparam int unsigned ADR_CUR_TIMER1   = 'h0d;
    localparam int unsigned ADR_STG_TIMER0   = 'h18;
    localparam int unsigned ADR_STG_TIMER1   = 'h19;
    localparam int unsigned ADR_STG_DATA     = 'h20;

    // CTL_CONTROL bits
    localparam int unsigned CTL_COMMIT       = 0;
    localparam int unsigned CTL_ENABLE       = 1;
    localparam int unsigned CTL_CLEAR        = 2;

    // CTL_STATUS bits
    localparam int unsigned STS_FULL         = 0;
    localparam int unsigned STS_EMPTY        = 1;
    localparam int unsigned STS_OVERFLOW     = 2;

endpackage

// File: rtl/jelly2_data_player_buffer.sv
// jelly2_data_player_buffer
//   Single-clock FIFO with a registered (1-cycle) RAM read. The entry
//   sitting in the read register is still counted as occupancy, so
//   count_o/full_o describe everything not yet handed to the consumer.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear_i       flush all entries (wins over push and pop)
//   s_data_i      entry to push, s_valid_i push request (dropped if full)
//   m_data_o      head entry, m_valid_o head present, m_ready_i pop head
//   count_o       occupancy, full_o / empty_o status

module jelly2_data_player_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PTR_WIDTH = 10,
    parameter string       RAM_TYPE  = "block"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic [WIDTH-1:0]     s_data_i,
    input  logic                 s_valid_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned DEPTH = 1 << PTR_WIDTH;
    localparam int unsigned CW    = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] count_q,  count_d;
    logic               rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]   ram_rdata;
    logic               push, pop, ram_empty, ram_rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign m_data_o  = ram_rdata;
    assign m_valid_o = rd_valid_q;

    // Occupancy includes the read register, so the RAM itself can never
    // hold more than DEPTH entries and needs no separate full check.
    assign push      = s_valid_i && !full_o && !clear_i;
    assign pop       = rd_valid_q && m_ready_i && !clear_i;
    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_rd    = !ram_empty && (!rd_valid_q || pop) && !clear_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + CW'(push);
            rd_ptr_d   = rd_ptr_q + CW'(ram_rd);
            count_d    = count_q + CW'(push) - CW'(pop);
            if (ram_rd) begin
                rd_valid_d = 1'b1;
            end else if (pop) begin
                rd_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // RAM storage; read data register is left unreset so it maps onto
    // the RAM's output register.
    if (RAM_TYPE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_q[PTR_WIDTH-1:0]] <= s_data_i;
            end
            if (ram_rd) begin
                ram_rdata <= mem[rd_ptr_q[PTR_WIDTH-1:0]];
            end
        end
    end else begin : g_block
        (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_q[PTR_WIDTH-1:0]] <= s_data_i;
            end
            if (ram_rd) begin
                ram_rdata <= mem[rd_ptr_q[PTR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: rtl/jelly2_data_player_fifo.sv
// jelly2_data_player_fifo
//   Playback block: the CPU stages NUM lanes (plus a release timestamp in
//   timed builds) over Wishbone and commits them into a FIFO; entries are
//   replayed on the m_* stream when enabled.
//   Optional: `define DATA_PLAYER_TIMED_EN holds each entry until the
//   free-running timer reaches its timestamp.
// Ports:
//   reset_n, clk     asynchronous active-low reset, single clock
//   cke              stream clock enable (timer and output transfer)
//   m_data/m_valid/m_ready  output stream
//   s_wb_*           zero-wait Wishbone slave (ack = stb)

module jelly2_data_player_fifo
    import jelly2_data_player_pkg::*;
#(
    parameter logic [31:0] CORE_ID          = 32'h527a_f003,
    parameter logic [31:0] CORE_VERSION     = 32'h0001_0000,
    parameter int unsigned NUM              = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned TIMER_WIDTH      = 64,
    parameter int unsigned FIFO_PTR_WIDTH   = 10,
    parameter string       FIFO_RAM_TYPE    = "block",
    parameter int unsigned WB_ADR_WIDTH     = 8,
    parameter int unsigned WB_DAT_WIDTH     = 32,
    parameter int unsigned WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
    parameter logic [1:0]  INIT_CTL_CONTROL = 2'b00
) (
    input  logic                                reset_n,
    input  logic                                clk,
    input  logic                                cke,
    output logic [NUM-1:0][DATA_WIDTH-1:0]      m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    input  logic [WB_ADR_WIDTH-1:0]             s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]             s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]             s_wb_dat_o,
    input  logic                                s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]             s_wb_sel_i,
    input  logic                                s_wb_stb_i,
    output logic                                s_wb_ack_o
);

    localparam int unsigned DATA_BITS = NUM * DATA_WIDTH;
`ifdef DATA_PLAYER_TIMED_EN
    localparam int unsigned TW2       = 2 * WB_DAT_WIDTH;
    localparam int unsigned BUF_WIDTH = TIMER_WIDTH + DATA_BITS;
`else
    localparam int unsigned BUF_WIDTH = DATA_BITS;
`endif

    function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
        input logic [WB_DAT_WIDTH-1:0] cur,
        input logic [WB_DAT_WIDTH-1:0] dat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        logic [WB_DAT_WIDTH-1:0] res;
        res = cur;
        for (int unsigned b = 0; b < WB_SEL_WIDTH; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = dat[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic                           wb_write, ctl_write, commit, clear;
    logic                           enable_q, overflow_q;
    logic [NUM-1:0][DATA_WIDTH-1:0] stg_data_q;
    logic [NUM-1:0][DATA_WIDTH-1:0] m_data_q;
    logic                           m_valid_q;
    logic [BUF_WIDTH-1:0]           buf_wdata, buf_rdata;
    logic                           buf_valid, buf_pop, buf_full, buf_empty;
    logic [FIFO_PTR_WIDTH:0]        buf_count;
    logic                           ts_ok, xfer;

    assign s_wb_ack_o = s_wb_stb_i;
    assign wb_write   = s_wb_stb_i && s_wb_we_i;
    assign ctl_write  = wb_write && (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_CONTROL)) && s_wb_sel_i[0];
    assign commit     = ctl_write && s_wb_dat_i[CTL_COMMIT];
    assign clear      = ctl_write && s_wb_dat_i[CTL_CLEAR];

`ifdef DATA_PLAYER_TIMED_EN
    logic [TIMER_WIDTH-1:0] timer_q, stg_timer_q, head_lag;
    logic [TW2-1:0]         timer_ext, stg_timer_ext;

    assign timer_ext     = TW2'(timer_q);
    assign stg_timer_ext = TW2'(stg_timer_q);
    assign buf_wdata     = {stg_timer_q, stg_data_q};

    // Wrap-safe "timer has reached ts": the modular difference is
    // non-negative when read as a signed value.
    assign head_lag      = timer_q - buf_rdata[BUF_WIDTH-1 -: TIMER_WIDTH];
    assign ts_ok         = !head_lag[TIMER_WIDTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q     <= '0;
            stg_timer_q <= '0;
        end else begin
            if (cke) begin
                timer_q <= timer_q + TIMER_WIDTH'(1);
            end
            if (wb_write && s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_TIMER0)) begin
                stg_timer_q <= TIMER_WIDTH'({stg_timer_ext[TW2-1:WB_DAT_WIDTH],
                    wb_merge(stg_timer_ext[WB_DAT_WIDTH-1:0], s_wb_dat_i, s_wb_sel_i)});
            end
            if (wb_write && s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_TIMER1)) begin
                stg_timer_q <= TIMER_WIDTH'({wb_merge(stg_timer_ext[TW2-1:WB_DAT_WIDTH], s_wb_dat_i, s_wb_sel_i),
                    stg_timer_ext[WB_DAT_WIDTH-1:0]});
            end
        end
    end
`else
    assign buf_wdata = stg_data_q;
    assign ts_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= INIT_CTL_CONTROL[CTL_ENABLE];
            overflow_q <= 1'b0;
            stg_data_q <= '0;
        end else begin
            if (ctl_write) begin
                enable_q <= s_wb_dat_i[CTL_ENABLE];
            end
            if (clear) begin
                overflow_q <= 1'b0;
            end else if (commit && buf_full) begin
                overflow_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM; i++) begin
                if (wb_write && s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_DATA + i)) begin
                    stg_data_q[i] <= DATA_WIDTH'(wb_merge(WB_DAT_WIDTH'(stg_data_q[i]), s_wb_dat_i, s_wb_sel_i));
                end
            end
        end
    end

    jelly2_data_player_buffer #(
        .WIDTH     (BUF_WIDTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH),
        .RAM_TYPE  (FIFO_RAM_TYPE)
    ) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (clear),
        .s_data_i  (buf_wdata),
        .s_valid_i (commit),
        .m_data_o  (buf_rdata),
        .m_valid_o (buf_valid),
        .m_ready_i (buf_pop),
        .count_o   (buf_count),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    // Output register refills from the FIFO head when idle or when the
    // current beat leaves; a clear holds the FIFO side but leaves a
    // beat already in the output register untouched.
    assign xfer    = m_valid_q && m_ready && cke;
    assign buf_pop = enable_q && buf_valid && ts_ok && (!m_valid_q || xfer) && !clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (buf_pop) begin
            m_valid_q <= 1'b1;
            m_data_q  <= buf_rdata[DATA_BITS-1:0];
        end else if (xfer) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    always_comb begin
        s_wb_dat_o = '0;
        if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CORE_ID)) begin
            s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CORE_VERSION)) begin
            s_wb_dat_o = WB_DAT_WIDTH'(CORE_VERSION);
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_CONTROL)) begin
            s_wb_dat_o[CTL_ENABLE] = enable_q;
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_STATUS)) begin
            s_wb_dat_o[STS_FULL]     = buf_full;
            s_wb_dat_o[STS_EMPTY]    = buf_empty;
            s_wb_dat_o[STS_OVERFLOW] = overflow_q;
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL_COUNT)) begin
            s_wb_dat_o = WB_DAT_WIDTH'(buf_count);
`ifdef DATA_PLAYER_TIMED_EN
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CUR_TIMER0)) begin
            s_wb_dat_o = timer_ext[WB_DAT_WIDTH-1:0];
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CUR_TIMER1)) begin
            s_wb_dat_o = timer_ext[TW2-1:WB_DAT_WIDTH];
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_TIMER0)) begin
            s_wb_dat_o = stg_timer_ext[WB_DAT_WIDTH-1:0];
        end else if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_TIMER1)) begin
            s_wb_dat_o = stg_timer_ext[TW2-1:WB_DAT_WIDTH];
`endif
        end
        for (int unsigned i = 0; i < NUM; i++) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_STG_DATA + i)) begin
                s_wb_dat_o = WB_DAT_WIDTH'(stg_data_q[i]);
            end
        end
    end

endmodule
